// File: rtl/ts_fifo_reader.sv
// Bus-side consumer for the 64-bit timestamp FIFO: pops one entry into a holding
// register, exposes it as two 32-bit words, and prefetches the next entry once HI is read.
module ts_fifo_reader #(
    parameter logic [19:0] ADDR_BASE  = 20'h20,
    parameter int          RD_LATENCY = 1,
    parameter int          CNT_W      = 32
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [63:0] fifo_dout_i,
    input  logic [31:0] sys_addr_i,
    input  logic [31:0] sys_wdata_i,
    input  logic [3:0]  sys_sel_i,
    input  logic        sys_wen_i,
    input  logic        sys_ren_i,
    output logic [31:0] sys_rdata_o,
    output logic        sys_err_o,
    output logic        sys_ack_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

    state_t           state;
    state_t           state_next;
    logic [1:0]       lat_cnt;
    logic [1:0]       lat_cnt_next;
    logic             rd_en_next;
    logic             capture;

    logic [63:0]      hold;
    logic [CNT_W-1:0] count;
    logic [31:0]      count_ext;
    logic             underrun;
    logic             en;
    logic             valid;

    logic [19:0]      offset;
    logic             access;
    logic             hi_read;
    logic             ack_hi;
    logic             ctrl_wr;
    logic             clear;
    logic [31:0]      rd_mux;
    logic             unused;

    assign valid     = (state == FULL);
    assign offset    = sys_addr_i[19:0] - ADDR_BASE;
    assign access    = sys_wen_i | sys_ren_i;
    assign hi_read   = sys_ren_i && (offset == 20'h08);
    assign ack_hi    = hi_read && valid;
    assign ctrl_wr   = sys_wen_i && (offset == 20'h10);
    assign clear     = ctrl_wr && sys_wdata_i[0];
    assign sys_err_o = 1'b0;
    assign unused    = ^{sys_sel_i, sys_addr_i[31:20], sys_wdata_i[31:2]};

    // The read enable is registered, so it is high during the first WAIT cycle and the
    // FIFO word arrives RD_LATENCY cycles later, on the cycle where lat_cnt hits LAT_LAST.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        rd_en_next   = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty_i) begin
                    state_next   = WAIT;
                    rd_en_next   = 1'b1;
                    lat_cnt_next = 2'd0;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = FULL;
                end else begin
                    lat_cnt_next = lat_cnt + 2'd1;
                end
            end
            FULL: begin
                if (ack_hi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state        <= IDLE;
            lat_cnt      <= 2'd0;
            fifo_rd_en_o <= 1'b0;
        end else begin
            state        <= state_next;
            lat_cnt      <= lat_cnt_next;
            fifo_rd_en_o <= rd_en_next;
        end
    end

    // hold only moves on capture, so a LO/HI pair always belongs to one entry
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            hold <= 64'h0;
        end else if (capture) begin
            hold <= fifo_dout_i;
        end
    end

    // A clear in the same cycle as a HI acknowledge wins over the increment
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            count    <= '0;
            underrun <= 1'b0;
            en       <= 1'b1;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (ack_hi) begin
                count <= count + 1'b1;
            end
            if (clear) begin
                underrun <= 1'b0;
            end else if (hi_read && !valid) begin
                underrun <= 1'b1;
            end
            if (ctrl_wr) begin
                en <= sys_wdata_i[1];
            end
        end
    end

    always_comb begin
        count_ext              = 32'h0;
        count_ext[CNT_W-1:0]   = count;
        rd_mux                 = 32'hFFFF_FFFF;
        case (offset)
            20'h00:  rd_mux = {29'h0, underrun, fifo_empty_i, valid};
            20'h04:  rd_mux = hold[31:0];
            20'h08:  rd_mux = hold[63:32];
            20'h0C:  rd_mux = count_ext;
            20'h10:  rd_mux = {30'h0, en, 1'b0};
            default: rd_mux = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sys_ack_o   <= 1'b0;
            sys_rdata_o <= 32'h0;
        end else begin
            sys_ack_o <= access;
            if (access) begin
                sys_rdata_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_ts_fifo_reader.sv
// Bench for ts_fifo_reader: two instances (latency 1 / 32-bit count, latency 3 / 4-bit count)
// each fed by a behavioural FIFO, with expected bus read data queued in a scoreboard.
module tb_ts_fifo_reader;

    localparam logic [31:0] BASE       = 32'h20;
    localparam logic [31:0] OFF_STATUS = 32'h00;
    localparam logic [31:0] OFF_LO     = 32'h04;
    localparam logic [31:0] OFF_HI     = 32'h08;
    localparam logic [31:0] OFF_COUNT  = 32'h0C;
    localparam logic [31:0] OFF_CTRL   = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        empty [2] = '{1'b1, 1'b1};
    logic        rd_en [2];
    logic [63:0] dout  [2] = '{64'h0, 64'h0};
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        wen   [2];
    logic        ren   [2];
    logic        err   [2];
    logic        ack   [2];
    logic [3:0]  sel = 4'hF;

    int          vectors     = 0;
    int          miscompares = 0;
    int          pops [2]    = '{0, 0};
    int          viol        = 0;
    logic [63:0] fq0 [$];
    logic [63:0] fq1 [$];
    logic [31:0] sb  [$];
    logic [63:0] p1 = 64'h0;
    logic [63:0] p2 = 64'h0;

    always #5 clk = ~clk;

    ts_fifo_reader #(.ADDR_BASE(20'h20), .RD_LATENCY(1), .CNT_W(32)) dut0 (
        .sys_clk_i(clk), .sys_rstn_i(rst_n[0]), .fifo_empty_i(empty[0]), .fifo_rd_en_o(rd_en[0]),
        .fifo_dout_i(dout[0]), .sys_addr_i(addr[0]), .sys_wdata_i(wdata[0]), .sys_sel_i(sel),
        .sys_wen_i(wen[0]), .sys_ren_i(ren[0]), .sys_rdata_o(rdata[0]), .sys_err_o(err[0]),
        .sys_ack_o(ack[0])
    );

    ts_fifo_reader #(.ADDR_BASE(20'h20), .RD_LATENCY(3), .CNT_W(4)) dut1 (
        .sys_clk_i(clk), .sys_rstn_i(rst_n[1]), .fifo_empty_i(empty[1]), .fifo_rd_en_o(rd_en[1]),
        .fifo_dout_i(dout[1]), .sys_addr_i(addr[1]), .sys_wdata_i(wdata[1]), .sys_sel_i(sel),
        .sys_wen_i(wen[1]), .sys_ren_i(ren[1]), .sys_rdata_o(rdata[1]), .sys_err_o(err[1]),
        .sys_ack_o(ack[1])
    );

    // Latency-1 FIFO: data is only valid on the single cycle after the pop
    always @(posedge clk) begin
        if (rd_en[0] && empty[0]) viol++;
        if (rd_en[0]) begin
            pops[0]++;
            if (fq0.size() > 0) dout[0] <= fq0.pop_front();
            else                dout[0] <= 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
            dout[0] <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
        empty[0] <= (fq0.size() == 0);
    end

    // Latency-3 FIFO
    always @(posedge clk) begin
        if (rd_en[1] && empty[1]) viol++;
        if (rd_en[1]) begin
            pops[1]++;
            if (fq1.size() > 0) p1 <= fq1.pop_front();
            else                p1 <= 64'hBAD1_BAD1_BAD1_BAD1;
        end else begin
            p1 <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
        p2       <= p1;
        dout[1]  <= p2;
        empty[1] <= (fq1.size() == 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_word(input int d, input logic [63:0] w);
        if (d == 0) fq0.push_back(w);
        else        fq1.push_back(w);
    endtask

    task automatic bus_access(input int d, input logic [31:0] a, input logic wr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic ak);
        @(negedge clk);
        addr[d]  = a;
        wdata[d] = wd;
        wen[d]   = wr;
        ren[d]   = !wr;
        @(negedge clk);
        wen[d] = 1'b0;
        ren[d] = 1'b0;
        rd     = rdata[d];
        ak     = ack[d];
    endtask

    task automatic bus_rd(input int d, input logic [31:0] a, input logic [31:0] want,
                          input string tag);
        logic [31:0] got;
        logic        ak;
        sb.push_back(want);
        bus_access(d, a, 1'b0, 32'h0, got, ak);
        chk({tag, "_ack"}, ak, 1);
        chk(tag, got, sb.pop_front());
    endtask

    task automatic bus_wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
        logic [31:0] got;
        logic        ak;
        bus_access(d, a, 1'b1, wd, got, ak);
        chk({tag, "_ack"}, ak, 1);
    endtask

    task automatic wait_valid(input int d, input string tag);
        logic [31:0] s;
        logic        ak;
        s = 32'h0;
        for (int i = 0; i < 40; i++) begin
            bus_access(d, BASE + OFF_STATUS, 1'b0, 32'h0, s, ak);
            if (s[0]) break;
        end
        chk({tag, "_valid_wait"}, s[0], 1);
    endtask

    task automatic en_gate_test(input int d, input logic [63:0] w, input string tag);
        int   base;
        int   lat;
        logic found;
        bus_wr(d, BASE + OFF_CTRL, 32'h0, {tag, "_dis"});
        bus_rd(d, BASE + OFF_CTRL, 32'h0, {tag, "_ctrl_off"});
        base = pops[d];
        push_word(d, w);
        repeat (100) @(negedge clk);
        chk({tag, "_no_pop"}, pops[d] - base, 0);
        bus_rd(d, BASE + OFF_STATUS, 32'h0, {tag, "_status_idle"});
        bus_wr(d, BASE + OFF_CTRL, 32'h2, {tag, "_ena"});
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (rd_en[d]) begin
                found = 1'b1;
                lat   = k;
                break;
            end
        end
        chk({tag, "_pop_within_2"}, (found && lat <= 2), 1);
        wait_valid(d, tag);
        bus_rd(d, BASE + OFF_LO, w[31:0], {tag, "_lo"});
        bus_rd(d, BASE + OFF_HI, w[63:32], {tag, "_hi"});
        bus_rd(d, BASE + OFF_CTRL, 32'h2, {tag, "_ctrl_on"});
        chk({tag, "_one_pop"}, pops[d] - base, 1);
    endtask

    initial begin
        int          base;
        logic        found;
        logic [63:0] w;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            wen[d]   = 1'b0;
            ren[d]   = 1'b0;
            addr[d]  = 32'h0;
            wdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rd_en%0d", d), rd_en[d], 0);
            chk($sformatf("rst_ack%0d", d), ack[d], 0);
            chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
            chk($sformatf("rst_err%0d", d), err[d], 0);
            rst_n[d] = 1'b1;
        end

        // single entry
        push_word(0, 64'h0000_0001_0000_0002);
        wait_valid(0, "t1");
        bus_rd(0, BASE + OFF_STATUS, 32'h3, "t1_status");
        bus_rd(0, BASE + OFF_LO, 32'h2, "t1_lo");
        bus_rd(0, BASE + OFF_HI, 32'h1, "t1_hi");
        bus_rd(0, BASE + OFF_COUNT, 32'h1, "t1_count");
        bus_rd(0, BASE + OFF_STATUS, 32'h2, "t1_status_after");
        chk("t1_pops", pops[0], 1);

        // four queued entries drained in order
        bus_wr(0, BASE + OFF_CTRL, 32'h3, "t2_clr");
        base = pops[0];
        for (int i = 0; i < 4; i++) push_word(0, {32'(i) + 32'hA0, 32'(i)});
        for (int i = 0; i < 4; i++) begin
            wait_valid(0, $sformatf("t2_w%0d", i));
            bus_rd(0, BASE + OFF_LO, 32'(i), $sformatf("t2_lo%0d", i));
            bus_rd(0, BASE + OFF_HI, 32'(i) + 32'hA0, $sformatf("t2_hi%0d", i));
        end
        bus_rd(0, BASE + OFF_COUNT, 32'h4, "t2_count");
        chk("t2_pops", pops[0] - base, 4);
        bus_rd(0, BASE + OFF_STATUS, 32'h2, "t2_status");

        // underrun on an empty FIFO, then clear
        bus_rd(0, BASE + OFF_HI, 32'hA3, "t3_stale_hi");
        bus_rd(0, BASE + OFF_STATUS, 32'h6, "t3_status_underrun");
        bus_rd(0, BASE + OFF_COUNT, 32'h4, "t3_count_kept");
        chk("t3_no_pop", pops[0] - base, 4);
        bus_wr(0, BASE + OFF_CTRL, 32'h3, "t3_clr");
        bus_rd(0, BASE + OFF_STATUS, 32'h2, "t3_status_cleared");
        bus_rd(0, BASE + OFF_COUNT, 32'h0, "t3_count_cleared");

        // prefetch enable gating at both latencies
        en_gate_test(0, 64'h1234_5678_9ABC_DEF0, "t4a");
        en_gate_test(1, 64'h0FED_CBA9_8765_4321, "t4b");

        // reset while a word is in flight
        base = pops[1];
        push_word(1, 64'h5555_AAAA_0000_0001);
        push_word(1, 64'h6666_BBBB_0000_0002);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (rd_en[1]) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_first_pop", found, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("t5_rst_rd_en", rd_en[1], 0);
        chk("t5_rst_ack", ack[1], 0);
        chk("t5_rst_rdata", rdata[1], 0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        wait_valid(1, "t5");
        bus_rd(1, BASE + OFF_LO, 32'h0000_0002, "t5_lo");
        bus_rd(1, BASE + OFF_HI, 32'h6666_BBBB, "t5_hi");
        bus_rd(1, BASE + OFF_COUNT, 32'h1, "t5_count");
        bus_rd(1, BASE + OFF_CTRL, 32'h2, "t5_en_reset");
        chk("t5_pops", pops[1] - base, 2);

        // 4-bit counter wrap, unmapped and read-only accesses
        bus_wr(1, BASE + OFF_CTRL, 32'h3, "t6_clr");
        for (int i = 0; i < 16; i++) begin
            w = {32'(i) + 32'hC0, 32'(i)};
            push_word(1, w);
            wait_valid(1, $sformatf("t6_w%0d", i));
            bus_rd(1, BASE + OFF_HI, w[63:32], $sformatf("t6_hi%0d", i));
            if (i == 14) bus_rd(1, BASE + OFF_COUNT, 32'hF, "t6_count_max");
        end
        bus_rd(1, BASE + OFF_COUNT, 32'h0, "t6_count_wrap");
        bus_rd(1, BASE + 32'h14, 32'hFFFF_FFFF, "t6_unmapped_hi");
        bus_rd(1, 32'h0, 32'hFFFF_FFFF, "t6_unmapped_lo");
        bus_rd(1, 32'h1230_0020, 32'h2, "t6_upper_addr_ignored");
        bus_wr(1, BASE + OFF_LO, 32'hFFFF_FFFF, "t6_ro_write");
        bus_wr(1, BASE + OFF_COUNT, 32'h7, "t6_ro_count_write");
        bus_rd(1, BASE + OFF_COUNT, 32'h0, "t6_count_unchanged");
        bus_rd(1, BASE + OFF_LO, 32'hF, "t6_lo_unchanged");

        chk("rd_en_while_empty", viol, 0);
        chk("err0", err[0], 0);
        chk("err1", err[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
